// File: rtl/chimp_pkg.sv
// Shared chimp game definitions: state encodings used by the controller,
// the chimp datapath and the VGA drawer.
package chimp_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned STRIKES_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHOW     = 3'd2,
        ST_CHOOSE   = 3'd3,
        ST_LEVEL_UP = 3'd4,
        ST_LOST     = 3'd5,
        ST_WIN      = 3'd6
    } chimp_state_e;

endpackage

// File: rtl/chimp_game_ctrl.sv
// Chimp memory-game controller: sequences tile loading, reveal, player
// choice checking, strikes, level progression and win/loss.
module chimp_game_ctrl
    import chimp_pkg::*;
#(
    parameter  int unsigned MAX_LEVEL   = 31,
    parameter  int unsigned START_LEVEL = 4,
    parameter  int unsigned STRIKES     = 3,
    localparam int unsigned NW          = $clog2(MAX_LEVEL + 1)
) (
    input  logic                 clk,
    input  logic                 iResetn,
    input  logic                 iEnter,
    input  logic [NW-1:0]        iPressNum,
    input  logic                 iLoadAck,
    output logic [STATE_W-1:0]   oState,
    output logic                 oLoadReq,
    output logic [NW-1:0]        oLoadIdx,
    output logic [NW-1:0]        oLevel,
    output logic [NW-1:0]        oExpected,
    output logic [STRIKES_W-1:0] oStrikes,
    output logic [NW-1:0]        oScore,
    output logic                 oLost,
    output logic                 oWin
);

    localparam logic [NW-1:0]        LVL_START = NW'(START_LEVEL);
    localparam logic [NW-1:0]        LVL_MAX   = NW'(MAX_LEVEL);
    localparam logic [NW-1:0]        ONE       = NW'(1);
    localparam logic [STRIKES_W-1:0] STRK_MAX  = STRIKES_W'(STRIKES);

    chimp_state_e         state, state_n;
    logic [NW-1:0]        level, level_n;
    logic [NW-1:0]        idx, idx_n;
    logic [NW-1:0]        expected, expected_n;
    logic [STRIKES_W-1:0] strikes, strikes_n, strikes_inc;
    logic [NW-1:0]        score, score_n;

    // State and counter registers
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state    <= ST_IDLE;
            level    <= LVL_START;
            idx      <= ONE;
            expected <= ONE;
            strikes  <= '0;
            score    <= '0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            idx      <= idx_n;
            expected <= expected_n;
            strikes  <= strikes_n;
            score    <= score_n;
        end
    end

    // Next-state and counter update logic; counters saturate rather than wrap
    always_comb begin
        state_n     = state;
        level_n     = level;
        idx_n       = idx;
        expected_n  = expected;
        strikes_n   = strikes;
        score_n     = score;
        strikes_inc = (strikes < STRK_MAX) ? strikes + STRIKES_W'(1) : strikes;

        case (state)
            ST_IDLE: begin
                if (iEnter) begin
                    state_n   = ST_LOAD;
                    level_n   = LVL_START;
                    strikes_n = '0;
                    score_n   = '0;
                    idx_n     = ONE;
                end
            end
            ST_LOAD: begin
                if (iLoadAck) begin
                    if (idx < level) idx_n   = idx + ONE;
                    else             state_n = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (iEnter) begin
                    state_n    = ST_CHOOSE;
                    expected_n = ONE;
                end
            end
            ST_CHOOSE: begin
                // A press always wins over a concurrent iEnter
                if (iPressNum != '0) begin
                    if (iPressNum == expected) begin
                        if (expected < level) expected_n = expected + ONE;
                        else                  state_n    = ST_LEVEL_UP;
                    end else begin
                        strikes_n = strikes_inc;
                        if (strikes_inc == STRK_MAX) begin
                            state_n = ST_LOST;
                        end else begin
                            state_n = ST_LOAD;
                            idx_n   = ONE;
                        end
                    end
                end
            end
            ST_LEVEL_UP: begin
                score_n = (score < LVL_MAX) ? score + ONE : score;
                if (level >= LVL_MAX) begin
                    state_n = ST_WIN;
                end else begin
                    level_n = level + ONE;
                    state_n = ST_LOAD;
                    idx_n   = ONE;
                end
            end
            ST_LOST, ST_WIN: begin
                if (iEnter) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs come straight from registers or decode of the state register
    assign oState    = state;
    assign oLoadReq  = (state == ST_LOAD);
    assign oLoadIdx  = idx;
    assign oLevel    = level;
    assign oExpected = expected;
    assign oStrikes  = strikes;
    assign oScore    = score;
    assign oLost     = (state == ST_LOST);
    assign oWin      = (state == ST_WIN);

endmodule

// File: tb/tb_chimp_game_ctrl.sv
// Directed scoreboard bench for chimp_game_ctrl: default configuration plus
// a MAX_LEVEL=5/START_LEVEL=5 instance for the win path.
module tb_chimp_game_ctrl;

    localparam int unsigned NW_A = 5;
    localparam int unsigned NW_B = 3;

    logic            clk;
    logic            rst_n;
    logic            enter;
    logic [NW_A-1:0] press_a;
    logic [NW_B-1:0] press_b;
    logic            ack;

    logic [2:0]      st_a, stk_a, st_b, stk_b;
    logic            lreq_a, lost_a, win_a, lreq_b, lost_b, win_b;
    logic [NW_A-1:0] lidx_a, lvl_a, exp_a, scr_a;
    logic [NW_B-1:0] lidx_b, lvl_b, exp_b, scr_b;

    chimp_game_ctrl dut_a (
        .clk(clk), .iResetn(rst_n), .iEnter(enter), .iPressNum(press_a),
        .iLoadAck(ack), .oState(st_a), .oLoadReq(lreq_a), .oLoadIdx(lidx_a),
        .oLevel(lvl_a), .oExpected(exp_a), .oStrikes(stk_a), .oScore(scr_a),
        .oLost(lost_a), .oWin(win_a)
    );

    chimp_game_ctrl #(.MAX_LEVEL(5), .START_LEVEL(5), .STRIKES(3)) dut_b (
        .clk(clk), .iResetn(rst_n), .iEnter(enter), .iPressNum(press_b),
        .iLoadAck(ack), .oState(st_b), .oLoadReq(lreq_b), .oLoadIdx(lidx_b),
        .oLevel(lvl_b), .oExpected(exp_b), .oStrikes(stk_b), .oScore(scr_b),
        .oLost(lost_b), .oWin(win_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } sb_entry_t;

    sb_entry_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic expect_val(input string tag, input int value);
        sb_entry_t e;
        e.tag   = tag;
        e.value = 32'(value);
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        sb_entry_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enter();
        enter = 1'b1; tick(); enter = 1'b0;
    endtask

    task automatic do_acks(input int n);
        for (int i = 0; i < n; i++) begin
            ack = 1'b1; tick(); ack = 1'b0;
        end
    endtask

    task automatic do_press(input int n, input logic with_enter);
        press_a = NW_A'(n);
        press_b = NW_B'(n);
        enter   = with_enter;
        tick();
        press_a = '0;
        press_b = '0;
        enter   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enter = 1'b0; ack = 1'b0; press_a = '0; press_b = '0;
        #12;
        // Reset values
        expect_val("rst_state", 0);   check(32'(st_a));
        expect_val("rst_level", 4);   check(32'(lvl_a));
        expect_val("rst_idx", 1);     check(32'(lidx_a));
        expect_val("rst_expected", 1); check(32'(exp_a));
        expect_val("rst_strikes", 0); check(32'(stk_a));
        expect_val("rst_score", 0);   check(32'(scr_a));
        expect_val("rst_flags", 0);   check(32'({lreq_a, lost_a, win_a}));
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
        expect_val("idle_wait", 0);   check(32'(st_a));

        // Start game: LOAD at level 4
        pulse_enter();
        expect_val("start_state", 1); check(32'(st_a));
        expect_val("start_loadreq", 1); check(32'(lreq_a));
        expect_val("start_idx", 1);   check(32'(lidx_a));
        pulse_enter();
        expect_val("load_enter_ignored_idx", 1); check(32'(lidx_a));
        expect_val("load_enter_ignored_st", 1);  check(32'(st_a));
        do_acks(3);
        expect_val("load_idx4", 4);   check(32'(lidx_a));
        do_acks(1);
        expect_val("show_state", 2);  check(32'(st_a));
        expect_val("show_loadreq", 0); check(32'(lreq_a));
        do_acks(1);
        do_press(1, 1'b0);
        expect_val("show_ack_press_ignored", 2); check(32'(st_a));

        // CHOOSE: correct then wrong press
        pulse_enter();
        expect_val("choose_state", 3); check(32'(st_a));
        expect_val("choose_expected", 1); check(32'(exp_a));
        do_press(1, 1'b0);
        expect_val("expected_2", 2);  check(32'(exp_a));
        do_press(3, 1'b0);
        expect_val("wrong_strikes", 1); check(32'(stk_a));
        expect_val("wrong_state", 1); check(32'(st_a));
        expect_val("wrong_level", 4); check(32'(lvl_a));
        expect_val("wrong_idx", 1);   check(32'(lidx_a));

        // Retry level 4 and clear it
        do_acks(4);
        pulse_enter();
        expect_val("retry_expected", 1); check(32'(exp_a));
        do_press(1, 1'b1);
        expect_val("enter_press_expected", 2); check(32'(exp_a));
        expect_val("enter_press_state", 3);    check(32'(st_a));
        tick();
        expect_val("no_press_hold", 2); check(32'(exp_a));
        do_press(2, 1'b0);
        do_press(3, 1'b0);
        do_press(4, 1'b0);
        expect_val("levelup_state", 4); check(32'(st_a));
        tick();
        expect_val("lu_level", 5);  check(32'(lvl_a));
        expect_val("lu_score", 1);  check(32'(scr_a));
        expect_val("lu_state", 1);  check(32'(st_a));
        expect_val("lu_idx", 1);    check(32'(lidx_a));

        // Two more misses at level 5 -> LOST
        do_acks(5);
        pulse_enter();
        do_press(2, 1'b0);
        expect_val("miss2_strikes", 2); check(32'(stk_a));
        do_acks(5);
        pulse_enter();
        do_press(1, 1'b0);
        do_press(5, 1'b0);
        expect_val("lost_flag", 1);    check(32'(lost_a));
        expect_val("lost_strikes", 3); check(32'(stk_a));
        expect_val("lost_state", 5);   check(32'(st_a));
        do_acks(1);
        expect_val("lost_hold_level", 5); check(32'(lvl_a));
        pulse_enter();
        expect_val("lost_idle", 0);       check(32'(st_a));
        expect_val("idle_strikes", 3);    check(32'(stk_a));
        expect_val("idle_lost_clear", 0); check(32'(lost_a));

        // New game, reset mid-LOAD at idx 3
        pulse_enter();
        expect_val("newgame_strikes", 0); check(32'(stk_a));
        expect_val("newgame_level", 4);   check(32'(lvl_a));
        do_acks(2);
        expect_val("midload_idx", 3);     check(32'(lidx_a));
        #2; rst_n = 1'b0; #1;
        expect_val("async_rst_state", 0);   check(32'(st_a));
        expect_val("async_rst_loadreq", 0); check(32'(lreq_a));
        @(posedge clk); #1; rst_n = 1'b1;
        do_acks(2);
        expect_val("post_rst_ack_state", 0); check(32'(st_a));
        expect_val("post_rst_ack_idx", 1);   check(32'(lidx_a));

        // Win path on MAX_LEVEL=5, START_LEVEL=5 instance
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        expect_val("b_rst_level", 5); check(32'(lvl_b));
        pulse_enter();
        do_acks(5);
        expect_val("b_show", 2); check(32'(st_b));
        pulse_enter();
        for (int n = 1; n <= 5; n++) do_press(n, 1'b0);
        expect_val("b_levelup", 4); check(32'(st_b));
        tick();
        expect_val("b_win_flag", 1);  check(32'(win_b));
        expect_val("b_win_state", 6); check(32'(st_b));
        expect_val("b_win_score", 1); check(32'(scr_b));
        expect_val("b_win_level", 5); check(32'(lvl_b));
        pulse_enter();
        expect_val("b_win_exit", 0);  check(32'(st_b));
        expect_val("b_win_clear", 0); check(32'(win_b));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
